// File: rtl/sha256_mem_responder.sv
// -----------------------------------------------------------------------------
// sha256_mem_responder
//
// Memory-side responder for the SHA-256 engine's memory master port. It holds
// a word-addressed RAM with a registered read path. The engine reads its
// message from this RAM and writes its digest back into it. A host port
// preloads the message and reads back the digest. A small run-control FSM
// issues the engine start pulse, follows the done handshake, and tracks which
// words of the digest window have been written.
//
// Parameters
//   DEPTH        number of 32-bit RAM words; addresses >= DEPTH are out of range
//   OUT_WORDS    number of digest words expected in the output window
//   TIMEOUT_CYC  watchdog limit in cycles (only with RESP_TIMEOUT_EN)
//
// Optional feature
//   RESP_TIMEOUT_EN  when defined, a watchdog counts cycles in WAIT_BUSY/RUN and
//                    forces COMPLETE with err=1 once TIMEOUT_CYC is reached.
//
// Ports
//   clk, reset_n         clock; asynchronous active-low reset
//   mem_we/mem_addr/     engine write enable, word address, write data
//   mem_write_data
//   mem_read_data        engine read data, RAM[mem_addr] one cycle later
//   sha_start            one-cycle start pulse to the engine
//   sha_done             engine done level (high while the engine is idle)
//   output_addr, go      digest window base and run request (base sampled on go)
//   host_we/host_re/     host write/read strobes, word address, write data
//   host_addr/host_wdata
//   host_rdata,          host read data and its one-cycle valid strobe
//   host_rvalid
//   hash_valid           digest window fully written and engine idle again
//   busy                 high in ARM, WAIT_BUSY and RUN
//   err                  sticky error; cleared by go or reset
// -----------------------------------------------------------------------------
module sha256_mem_responder #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned OUT_WORDS   = 8,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        sha_start,
    input  logic        sha_done,
    input  logic [15:0] output_addr,
    input  logic        go,
    input  logic        host_we,
    input  logic        host_re,
    input  logic [15:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic [31:0] host_rdata,
    output logic        host_rvalid,
    output logic        hash_valid,
    output logic        busy,
    output logic        err
);

    localparam int unsigned AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned MW          = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
    localparam logic [16:0] DEPTH_L     = 17'(DEPTH);
    localparam logic [16:0] OUT_WORDS_L = 17'(OUT_WORDS);

    if (DEPTH < 1 || DEPTH > 65536 || OUT_WORDS < 1 || OUT_WORDS > 65536 || TIMEOUT_CYC < 1)
    begin : g_param_check
        $error("sha256_mem_responder: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_BUSY,
        S_RUN,
        S_COMPLETE
    } state_e;

    state_e               state_q, state_d;
    logic [15:0]          base_q, base_d;
    logic [OUT_WORDS-1:0] mask_q, mask_d;
    logic                 hash_valid_q, hash_valid_d;
    logic                 err_q, err_d;
    logic                 sha_start_q, sha_start_d;
    logic                 busy_q, busy_d;
    logic [31:0]          mem_read_data_q, mem_read_data_d;
    logic [31:0]          host_rdata_q, host_rdata_d;
    logic                 host_rvalid_q, host_rvalid_d;

    logic [31:0]          ram [DEPTH];

    logic                 eng_in_range, host_in_range;
    logic                 eng_phase, host_phase;
    logic                 eng_wr_ok, host_wr_ok, host_rd_ok;
    logic [15:0]          win_off;
    logic                 in_window;
    logic                 tmo_hit;

    // Access qualification. Engine and host write phases never overlap, so
    // the RAM needs only one write port.
    always_comb begin
        eng_in_range  = {1'b0, mem_addr} < DEPTH_L;
        host_in_range = {1'b0, host_addr} < DEPTH_L;
        eng_phase     = (state_q == S_WAIT_BUSY) || (state_q == S_RUN);
        host_phase    = (state_q == S_IDLE) || (state_q == S_COMPLETE);
        eng_wr_ok     = mem_we && eng_phase && eng_in_range;
        host_wr_ok    = host_we && host_phase && host_in_range;
        host_rd_ok    = host_re && host_phase;
        // 16-bit difference, so a window near 0xFFFF wraps around to 0x0000.
        win_off       = mem_addr - base_q;
        in_window     = {1'b0, win_off} < OUT_WORDS_L;
    end

    // NOTE: the RAM array has no reset on purpose: its contents must survive
    // reset, and a reset would stop it mapping onto a memory macro.
    always_ff @(posedge clk) begin
        if (eng_wr_ok) begin
            ram[mem_addr[AW-1:0]] <= mem_write_data;
        end else if (host_wr_ok) begin
            ram[host_addr[AW-1:0]] <= host_wdata;
        end
    end

    // Read ports sample the array before this edge's write lands, which gives
    // read-before-write on same-address collisions.
    always_comb begin
        mem_read_data_d = eng_in_range ? ram[mem_addr[AW-1:0]] : 32'h0;
        host_rdata_d    = host_rdata_q;
        host_rvalid_d   = 1'b0;
        if (host_rd_ok) begin
            host_rvalid_d = 1'b1;
            host_rdata_d  = host_in_range ? ram[host_addr[AW-1:0]] : 32'h0;
        end
    end

`ifdef RESP_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

    // ARM is the only way into WAIT_BUSY, so clearing there clears on entry.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_hit   = 1'b0;
        if (state_q == S_ARM) begin
            tmo_cnt_d = '0;
        end else if (eng_phase) begin
            tmo_cnt_d = tmo_cnt_q + CW'(1);
            tmo_hit   = (tmo_cnt_q == CW'(TIMEOUT_CYC - 1));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // NOTE: every signal gets its default at the top of the block; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        mask_d       = mask_q;
        hash_valid_d = hash_valid_q;
        err_d        = err_q;

        unique case (state_q)
            S_IDLE, S_COMPLETE: begin
                if (go) begin
                    state_d      = S_ARM;
                    base_d       = output_addr;
                    mask_d       = '0;
                    hash_valid_d = 1'b0;
                    err_d        = 1'b0;
                end
            end
            S_ARM: state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                // Only a done level that falls after start proves the engine
                // took the request; a stale high level is ignored.
                if (tmo_hit) begin
                    state_d = S_COMPLETE;
                    err_d   = 1'b1;
                end else if (!sha_done) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (eng_wr_ok && in_window) begin
                    mask_d[win_off[MW-1:0]] = 1'b1;
                end
                if (tmo_hit) begin
                    state_d      = S_COMPLETE;
                    hash_valid_d = 1'b0;
                    err_d        = 1'b1;
                end else if (sha_done) begin
                    state_d = S_COMPLETE;
                    if (&mask_d) begin
                        hash_valid_d = 1'b1;
                    end else begin
                        hash_valid_d = 1'b0;
                        err_d        = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Dropped engine writes and host strobes outside the host phase.
        if ((mem_we && !eng_wr_ok) || ((host_we || host_re) && !host_phase)) begin
            err_d = 1'b1;
        end

        // Outputs are registered from the next state so they never glitch.
        sha_start_d = (state_d == S_ARM);
        busy_d      = (state_d == S_ARM) || (state_d == S_WAIT_BUSY) || (state_d == S_RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            base_q          <= '0;
            mask_q          <= '0;
            hash_valid_q    <= 1'b0;
            err_q           <= 1'b0;
            sha_start_q     <= 1'b0;
            busy_q          <= 1'b0;
            mem_read_data_q <= '0;
            host_rdata_q    <= '0;
            host_rvalid_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            mask_q          <= mask_d;
            hash_valid_q    <= hash_valid_d;
            err_q           <= err_d;
            sha_start_q     <= sha_start_d;
            busy_q          <= busy_d;
            mem_read_data_q <= mem_read_data_d;
            host_rdata_q    <= host_rdata_d;
            host_rvalid_q   <= host_rvalid_d;
        end
    end

    assign mem_read_data = mem_read_data_q;
    assign sha_start     = sha_start_q;
    assign host_rdata    = host_rdata_q;
    assign host_rvalid   = host_rvalid_q;
    assign hash_valid    = hash_valid_q;
    assign busy          = busy_q;
    assign err           = err_q;

endmodule

// File: tb/tb_sha256_mem_responder.sv
// -----------------------------------------------------------------------------
// Testbench for sha256_mem_responder. A second instance with a full 64K-word
// RAM shares all inputs and is used where the window must wrap through 0x0000
// with every address in range.
// -----------------------------------------------------------------------------
module tb_sha256_mem_responder;

    localparam int unsigned DEPTH       = 256;
    localparam int unsigned OUT_WORDS   = 8;
    localparam int unsigned TIMEOUT_CYC = 4096;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        sha_done;
    logic [15:0] output_addr;
    logic        go;
    logic        host_we, host_re;
    logic [15:0] host_addr;
    logic [31:0] host_wdata;

    logic [31:0] mem_read_data, host_rdata;
    logic        sha_start, host_rvalid, hash_valid, busy, err;
    logic [31:0] w_mem_read_data, w_host_rdata;
    logic        w_sha_start, w_host_rvalid, w_hash_valid, w_busy, w_err;

    always #5 clk = ~clk;

    sha256_mem_responder #(.DEPTH(DEPTH), .OUT_WORDS(OUT_WORDS), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .reset_n(reset_n), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .sha_start(sha_start), .sha_done(sha_done), .output_addr(output_addr), .go(go),
        .host_we(host_we), .host_re(host_re), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid), .hash_valid(hash_valid),
        .busy(busy), .err(err)
    );

    sha256_mem_responder #(.DEPTH(65536), .OUT_WORDS(OUT_WORDS), .TIMEOUT_CYC(TIMEOUT_CYC)) dut_wide (
        .clk(clk), .reset_n(reset_n), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(w_mem_read_data),
        .sha_start(w_sha_start), .sha_done(sha_done), .output_addr(output_addr), .go(go),
        .host_we(host_we), .host_re(host_re), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(w_host_rdata), .host_rvalid(w_host_rvalid), .hash_valid(w_hash_valid),
        .busy(w_busy), .err(w_err)
    );

    int checks = 0;
    int errors = 0;
    int start_pulses = 0;

    logic [31:0] model_ram [DEPTH];
    logic [31:0] host_q[$];
    logic [31:0] eng_q[$];

    typedef struct {
        logic        we;
        logic        re;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        exp_rvalid;
        logic [31:0] exp_rdata;
    } host_vec_t;

    host_vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: one expected entry per read issued on the previous cycle.
    always @(posedge clk) begin
        #2;
        if (sha_start === 1'b1) start_pulses++;
        check("host_rvalid", {31'b0, host_rvalid}, {31'b0, (host_q.size() > 0)});
        if (host_q.size() > 0) check("host_rdata", host_rdata, host_q.pop_front());
        if (eng_q.size() > 0) check("mem_read_data", mem_read_data, eng_q.pop_front());
    end

    function automatic logic [31:0] model_rd(input logic [15:0] a);
        return (32'(a) < DEPTH) ? model_ram[a[7:0]] : 32'h0;
    endfunction

    function automatic logic [31:0] digest_word(input int i);
        return 32'h6A09E667 ^ (32'(i) * 32'h01010101);
    endfunction

    task automatic host_write(input logic [15:0] a, input logic [31:0] d);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        if (32'(a) < DEPTH) model_ram[a[7:0]] = d;
        @(negedge clk);
        host_we = 1'b0;
    endtask

    task automatic host_read(input logic [15:0] a);
        host_re = 1'b1; host_addr = a;
        host_q.push_back(model_rd(a));
        @(negedge clk);
        host_re = 1'b0;
    endtask

    task automatic eng_read(input logic [15:0] a);
        logic [31:0] exp;
        mem_addr = a;
        exp = model_rd(a);
        if (!$isunknown(exp)) eng_q.push_back(exp);
        @(negedge clk);
    endtask

    // The read port sees the old word on a write, then the model takes the new one.
    task automatic eng_write(input logic [15:0] a, input logic [31:0] d);
        logic [31:0] exp;
        mem_we = 1'b1; mem_addr = a; mem_write_data = d;
        exp = model_rd(a);
        if (!$isunknown(exp)) eng_q.push_back(exp);
        if (32'(a) < DEPTH) model_ram[a[7:0]] = d;
        @(negedge clk);
        mem_we = 1'b0;
    endtask

    task automatic start_run(input logic [15:0] base);
        output_addr = base; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("sha_start_after_go", {31'b0, sha_start}, 32'd1);
        check("busy_in_arm", {31'b0, busy}, 32'd1);
        check("err_cleared_by_go", {31'b0, err}, 32'd0);
        check("hash_valid_cleared_by_go", {31'b0, hash_valid}, 32'd0);
    endtask

    // Engine drops done after seeing start: one cycle to WAIT_BUSY, one to RUN.
    task automatic engine_busy();
        sha_done = 1'b0;
        @(negedge clk);
        check("sha_start_single_cycle", {31'b0, sha_start}, 32'd0);
        @(negedge clk);
    endtask

    task automatic finish_run(input logic exp_valid, input logic exp_err);
        check("hash_valid_before_done", {31'b0, hash_valid}, 32'd0);
        sha_done = 1'b1;
        @(negedge clk);
        check("hash_valid_at_complete", {31'b0, hash_valid}, {31'b0, exp_valid});
        check("err_at_complete", {31'b0, err}, {31'b0, exp_err});
        check("busy_at_complete", {31'b0, busy}, 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mem_read_data"}, mem_read_data, 32'd0);
        check({tag, "_sha_start"}, {31'b0, sha_start}, 32'd0);
        check({tag, "_host_rdata"}, host_rdata, 32'd0);
        check({tag, "_host_rvalid"}, {31'b0, host_rvalid}, 32'd0);
        check({tag, "_hash_valid"}, {31'b0, hash_valid}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_err"}, {31'b0, err}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 16'h0010, 32'hA5A50001, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 16'h0010, 32'h0,        1'b1, 32'hA5A50001};
        vecs[2] = '{1'b1, 1'b1, 16'h0010, 32'h5A5A0002, 1'b1, 32'hA5A50001};
        vecs[3] = '{1'b0, 1'b1, 16'h0010, 32'h0,        1'b1, 32'h5A5A0002};
        vecs[4] = '{1'b1, 1'b0, 16'h00FF, 32'hFFFF0000, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 1'b1, 16'h00FF, 32'h0,        1'b1, 32'hFFFF0000};
        vecs[6] = '{1'b1, 1'b0, 16'h0100, 32'h12345678, 1'b0, 32'h0};
        vecs[7] = '{1'b0, 1'b1, 16'h0100, 32'h0,        1'b1, 32'h0};
        vecs[8] = '{1'b0, 1'b1, 16'hFFFF, 32'h0,        1'b1, 32'h0};

        reset_n = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_write_data = '0;
        sha_done = 1'b1; output_addr = '0; go = 1'b0;
        host_we = 1'b0; host_re = 1'b0; host_addr = '0; host_wdata = '0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Host port vectors in IDLE: collisions, last word, out of range.
        for (int i = 0; i < 9; i++) begin
            host_we = vecs[i].we; host_re = vecs[i].re;
            host_addr = vecs[i].addr; host_wdata = vecs[i].wdata;
            if (vecs[i].we && 32'(vecs[i].addr) < DEPTH) model_ram[vecs[i].addr[7:0]] = vecs[i].wdata;
            if (vecs[i].exp_rvalid) host_q.push_back(vecs[i].exp_rdata);
            @(negedge clk);
        end
        host_we = 1'b0; host_re = 1'b0;
        check("err_after_idle_host_access", {31'b0, err}, 32'd0);

        // Basic hash run.
        for (int i = 0; i < 20; i++) host_write(16'(i), 32'h01234675 + 32'(i));
        start_pulses = 0;
        start_run(16'h0080);
        engine_busy();
        for (int i = 0; i < 20; i++) eng_read(16'(i));
        eng_write(16'h0083, 32'hBAD0BAD0);
        for (int i = 0; i < 8; i++) eng_write(16'h0080 + 16'(i), digest_word(i));
        finish_run(1'b1, 1'b0);
        check("start_pulse_count", 32'(start_pulses), 32'd1);
        for (int i = 0; i < 8; i++) host_read(16'h0080 + 16'(i));
        @(negedge clk);

        // Stale done held high through ARM, then an incomplete window.
        output_addr = 16'h0080; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("stale_sha_start", {31'b0, sha_start}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stale_busy", {31'b0, busy}, 32'd1);
            check("stale_hash_valid", {31'b0, hash_valid}, 32'd0);
        end
        sha_done = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 7; i++) eng_write(16'h0080 + 16'(i), ~digest_word(i));
        finish_run(1'b0, 1'b1);

        // Host access while busy is ignored and flags err.
        start_run(16'h0080);
        engine_busy();
        host_we = 1'b1; host_re = 1'b1; host_addr = 16'h0005; host_wdata = 32'hDEADBEEF;
        @(negedge clk);
        host_we = 1'b0; host_re = 1'b0;
        check("err_after_host_in_run", {31'b0, err}, 32'd1);
        check("busy_after_host_in_run", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) eng_write(16'h0080 + 16'(i), digest_word(i + 8));
        finish_run(1'b1, 1'b1);
        host_read(16'h0005);

        // Out-of-range engine write and read.
        start_run(16'h0090);
        engine_busy();
        eng_write(16'h0100, 32'hCAFEF00D);
        check("err_after_oor_write", {31'b0, err}, 32'd1);
        eng_read(16'h0100);
        for (int i = 0; i < 8; i++) eng_write(16'h0090 + 16'(i), digest_word(i + 16));
        finish_run(1'b1, 1'b1);
        host_read(16'h0100);

        // Window wrapping through 0x0000.
        start_run(16'hFFFC);
        engine_busy();
        for (int i = 0; i < 8; i++) eng_write(16'hFFFC + 16'(i), digest_word(i + 24));
        finish_run(1'b0, 1'b1);
        check("wrap_wide_hash_valid", {31'b0, w_hash_valid}, 32'd1);
        check("wrap_wide_err", {31'b0, w_err}, 32'd0);
        for (int i = 0; i < 4; i++) host_read(16'(i));

        // Reset in the middle of a run.
        start_run(16'h0080);
        engine_busy();
        eng_write(16'h0080, 32'h0BADF00D);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midrun_reset");
        @(negedge clk);
        reset_n = 1'b1; sha_done = 1'b1;
        @(negedge clk);
        host_read(16'h0000);
        start_run(16'h0080);
        engine_busy();
        for (int i = 0; i < 8; i++) eng_write(16'h0080 + 16'(i), digest_word(i + 32));
        finish_run(1'b1, 1'b0);

`ifdef RESP_TIMEOUT_EN
        // Watchdog with done stuck low.
        start_run(16'h0080);
        sha_done = 1'b0;
        @(negedge clk);
        repeat (TIMEOUT_CYC - 1) @(negedge clk);
        check("timeout_err_early", {31'b0, err}, 32'd0);
        check("timeout_busy_early", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check("timeout_err", {31'b0, err}, 32'd1);
        check("timeout_hash_valid", {31'b0, hash_valid}, 32'd0);
        check("timeout_busy", {31'b0, busy}, 32'd0);
        sha_done = 1'b1;
`endif

        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256_mem_responder.md
Name: sha256_mem_responder

Overview:
- Memory-side responder for the SHA-256 engine's memory master port: a word-addressed synchronous RAM with a registered read path.
- Serves the engine's message reads and captures its hash writes.
- Also provides a host port to preload the message and read back the digest.
- Runs a run-control FSM: issues the engine start pulse, tracks the done handshake and coverage of the output window, and flags a valid hash.

Parameters:
DEPTH, 256, number of 32-bit words in RAM; addresses >= DEPTH are out of range.
OUT_WORDS, 8, number of digest words expected in the output window.
TIMEOUT_CYC, 4096, watchdog limit in cycles (used only with RESP_TIMEOUT_EN).

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
mem_we  in  1  engine write enable
mem_addr  in  16  engine word address
mem_write_data  in  32  engine write data
mem_read_data  out  32  engine read data, registered
sha_start  out  1  one-cycle start pulse to the engine
sha_done  in  1  engine done (high while the engine is idle)
output_addr  in  16  base of the digest window; sampled on go
go  in  1  host request to run one hash
host_we  in  1  host write strobe
host_re  in  1  host read strobe
host_addr  in  16  host word address
host_wdata  in  32  host write data
host_rdata  out  32  host read data
host_rvalid  out  1  host_rdata valid, one cycle after host_re
hash_valid  out  1  digest fully written and engine idle again
busy  out  1  high in ARM, WAIT_BUSY and RUN
err  out  1  sticky error flag; cleared by go or reset

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk.
  - All outputs reset to 0. State goes to IDLE, the window mask clears, the base register clears.
  - RAM contents are not reset and are retained across reset.
- Engine read path:
  - Every cycle, mem_read_data <= RAM[mem_addr] (read latency 1).
  - Out-of-range address: mem_read_data <= 0.
  - On a same-cycle write and read to the same address, the old data is returned (read-before-write).
- Engine writes:
  - Accepted only in WAIT_BUSY and RUN, and only when mem_addr < DEPTH.
  - Otherwise the write is dropped and err is set.
- Host access:
  - Allowed only in IDLE and COMPLETE.
  - host_we writes host_wdata.
  - host_re returns RAM data (0 if out of range) on host_rdata, with host_rvalid pulsed the next cycle.
  - Host strobes in any other state are ignored (no rvalid) and set err.
  - If host_we and host_re occur in the same cycle: the write commits and the read returns the old data.
- FSM states: IDLE, ARM, WAIT_BUSY, RUN, COMPLETE.
  - IDLE/COMPLETE, go=1: latch output_addr into the base register, clear mask, clear hash_valid and err, go to ARM. go in any other state is ignored.
  - ARM: sha_start=1 for exactly this one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: wait for sha_done=0, then go to RUN. A done level that is already high before start must not count as completion.
  - RUN: each accepted engine write with base <= addr < base+OUT_WORDS sets mask bit (addr-base).
    - Address subtraction is 16-bit; the window wraps modulo 2^16.
    - Repeated writes to the same word are legal; the last value wins.
    - When sha_done=1: if the mask is all ones, go to COMPLETE with hash_valid=1; otherwise go to COMPLETE with hash_valid=0 and err=1.
  - COMPLETE: hash_valid holds until the next go or reset.
- Asynchronous reset in any state aborts the run immediately; sha_start never glitches.

Optional Feature:
- Macro: RESP_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT_BUSY and counts in WAIT_BUSY and RUN.
  - When it reaches TIMEOUT_CYC, the FSM goes to COMPLETE with err=1 and hash_valid=0.
- Undefined: no counter; the FSM waits indefinitely.

Test Plan:
- Basic hash run:
  - Stimulus: host writes 20 words 0x01234675.. at 0x0000, then go with output_addr=0x0080.
  - Response:
    - sha_start pulses once, 1 cycle after go.
    - The engine reads back the same data 1 cycle after each address.
    - hash_valid=1 once all 8 words 0x0080–0x0087 are written and sha_done rises.
    - Host reads of 0x0080–0x0087 return the written digest.
- Stale done:
  - Stimulus: sha_done held high throughout ARM and for 3 cycles after.
  - Response: FSM stays in WAIT_BUSY, hash_valid=0.
- Incomplete window:
  - Stimulus: the model engine writes only 0x0080–0x0086, then raises done.
  - Response: COMPLETE with hash_valid=0, err=1.
- Host during run:
  - Stimulus: host_we to 0x0005 with data 0xDEADBEEF while busy=1.
  - Response: write ignored (a later read returns the old word), err=1, no host_rvalid.
- Range and wrap:
  - Engine write to 0x0100 with DEPTH=256: dropped, err=1, read of that address returns 0.
  - output_addr=0xFFFC: window wraps to 0xFFFC–0x0003.
- Reset mid-run:
  - Stimulus: reset_n low during RUN.
  - Response: all outputs 0 and state IDLE. RAM word 0x0000 is unchanged. A subsequent go runs normally.
  - With RESP_TIMEOUT_EN and sha_done stuck low: err=1 after exactly TIMEOUT_CYC cycles.
